// File: rtl/spi_slave_trx_sync.sv
// Oversampled SPI slave character transceiver: CPOL/CPHA modes, MSB/LSB order, 4..CHAR_NBITS bits.
// Optional internal loopback is compiled in by defining SPI_SLAVE_LOOP_EN.
module spi_slave_trx_sync #(
   parameter int CHAR_NBITS = 32,
   parameter int LEN_W      = $clog2(CHAR_NBITS)
) (
   input  logic                  S_SYSCLK,
   input  logic                  S_RESETN,
   input  logic                  S_ENABLE,
   input  logic                  S_CPOL,
   input  logic                  S_CPHA,
   input  logic                  S_REV,
   input  logic [LEN_W-1:0]      S_CHAR_LEN,
   input  logic                  S_LOOP,
   input  logic [CHAR_NBITS-1:0] S_TX_DATA,
   input  logic                  S_TX_VALID,
   output logic                  S_TX_READY,
   output logic [CHAR_NBITS-1:0] S_RX_DATA,
   output logic                  S_RX_VALID,
   input  logic                  S_RX_READY,
   output logic                  S_TX_UDR,
   output logic                  S_RX_OVR,
   input  logic                  S_ERR_CLR,
   output logic                  S_BUSY,
   input  logic                  S_SPI_CS,
   input  logic                  S_SPI_SCK,
   input  logic                  S_SPI_MOSI,
   output logic                  S_SPI_MISO,
   output logic                  S_SPI_MISO_OE
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [CHAR_NBITS-1:0] ONES   = {CHAR_NBITS{1'b1}};
   localparam logic [LEN_W-1:0]      LEN_MIN = LEN_W'(3);

   state_t                  state_q, state_d;
   logic [2:0]              sck_sync_q, sck_sync_d;
   logic [2:0]              cs_sync_q, cs_sync_d;
   logic [1:0]              mosi_sync_q, mosi_sync_d;
   logic                    cpol_q, cpol_d, cpha_q, cpha_d, rev_q, rev_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [CHAR_NBITS-1:0]   tx_shift_q, tx_shift_d;
   logic [CHAR_NBITS-1:0]   rx_shift_q, rx_shift_d;
   logic [CHAR_NBITS-1:0]   tx_hold_q, tx_hold_d;
   logic                    tx_empty_q, tx_empty_d;
   logic [CHAR_NBITS-1:0]   rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    rx_done_q, rx_done_d;
   logic                    udr_q, udr_d, ovr_q, ovr_d;
   logic                    miso_q, miso_d;
   logic                    oe_q, oe_d;

   logic sck_rise_s, sck_fall_s, lead_s, trail_s;
   logic start_s, abort_s, sample_s, shift_s;
   logic load_s, udr_set_s, ovr_set_s, rx_bit_s;

   // Bit position within the character for the n-th transferred bit
   function automatic logic [LEN_W-1:0] bit_pos(input logic rev, input logic [LEN_W-1:0] len_m1,
                                                input logic [LEN_W-1:0] cnt);
      return rev ? (len_m1 - cnt) : cnt;
   endfunction

   function automatic logic [CHAR_NBITS-1:0] len_mask(input logic [LEN_W-1:0] len_m1);
      logic [CHAR_NBITS-1:0] m;
      for (int i = 0; i < CHAR_NBITS; i++) begin
         m[i] = (i <= int'(len_m1));
      end
      return m;
   endfunction

   assign sck_rise_s = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall_s = ~sck_sync_q[1] & sck_sync_q[2];
   assign lead_s     = cpol_q ? sck_fall_s : sck_rise_s;
   assign trail_s    = cpol_q ? sck_rise_s : sck_fall_s;
   assign start_s    = (state_q == ST_IDLE) & ~cs_sync_q[1] & S_ENABLE;
   // CS counts as released while it is high in either of the last two stages
   assign abort_s    = (state_q == ST_ACTIVE) & (cs_sync_q[1] | cs_sync_q[2] | ~S_ENABLE);
   assign sample_s   = (state_q == ST_ACTIVE) & ~abort_s & (cpha_q ? trail_s : lead_s);
   assign shift_s    = (state_q == ST_ACTIVE) & ~abort_s & (cpha_q ? lead_s : trail_s);

`ifdef SPI_SLAVE_LOOP_EN
   assign rx_bit_s = S_LOOP ? miso_q : mosi_sync_q[1];
`else
   logic loop_unused_s;
   assign loop_unused_s = S_LOOP;
   assign rx_bit_s      = mosi_sync_q[1];
`endif

   // Next-state, datapath and handshake logic
   always_comb begin
      state_d     = state_q;
      sck_sync_d  = {sck_sync_q[1:0], S_SPI_SCK};
      cs_sync_d   = {cs_sync_q[1:0], S_SPI_CS};
      mosi_sync_d = {mosi_sync_q[0], S_SPI_MOSI};
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      rev_d       = rev_q;
      len_d       = len_q;
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      tx_hold_d   = tx_hold_q;
      tx_empty_d  = tx_empty_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      rx_done_d   = 1'b0;
      miso_d      = miso_q;
      load_s      = 1'b0;
      udr_set_s   = 1'b0;
      ovr_set_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d   = ST_ACTIVE;
               cpol_d    = S_CPOL;
               cpha_d    = S_CPHA;
               rev_d     = S_REV;
               len_d     = (S_CHAR_LEN < LEN_MIN) ? LEN_MIN : S_CHAR_LEN;
               bit_cnt_d = {LEN_W{1'b0}};
               load_s    = 1'b1;
            end else begin
               bit_cnt_d = {LEN_W{1'b0}};
            end
         end
         ST_ACTIVE: begin
            if (abort_s) begin
               state_d = ST_IDLE;
            end else if (sample_s) begin
               rx_shift_d[bit_pos(rev_q, len_q, bit_cnt_q)] = rx_bit_s;
               if (bit_cnt_q == len_q) begin
                  bit_cnt_d = {LEN_W{1'b0}};
                  rx_done_d = 1'b1;
                  load_s    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + LEN_W'(1);
               end
            end else if (shift_s) begin
               miso_d = tx_shift_q[bit_pos(rev_q, len_q, bit_cnt_q)];
            end else begin
               miso_d = miso_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Load uses the pre-write holding content; a same-cycle write lands afterwards
      if (load_s) begin
         if (!tx_empty_q) begin
            tx_shift_d = tx_hold_q;
            tx_empty_d = 1'b1;
         end else begin
            tx_shift_d = ONES;
            udr_set_s  = 1'b1;
         end
         if (!cpha_d) begin
            miso_d = tx_shift_d[bit_pos(rev_d, len_d, {LEN_W{1'b0}})];
         end else begin
            miso_d = miso_q;
         end
      end
      if (S_TX_VALID && tx_empty_q) begin
         tx_hold_d  = S_TX_DATA;
         tx_empty_d = 1'b0;
      end

      if (rx_done_q) begin
         if (!rx_valid_q || S_RX_READY) begin
            rx_data_d  = rx_shift_q & len_mask(len_q);
            rx_valid_d = 1'b1;
         end else begin
            ovr_set_s = 1'b1;
         end
      end else if (rx_valid_q && S_RX_READY) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end

      udr_d = (udr_q & ~S_ERR_CLR) | udr_set_s;
      ovr_d = (ovr_q & ~S_ERR_CLR) | ovr_set_s;

      if (state_d == ST_IDLE) begin
         miso_d = 1'b1;
      end
`ifdef SPI_SLAVE_LOOP_EN
      oe_d = (state_d == ST_ACTIVE) & ~S_LOOP;
`else
      oe_d = (state_d == ST_ACTIVE);
`endif
   end

   // State and datapath registers
   always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
      if (!S_RESETN) begin
         state_q     <= ST_IDLE;
         sck_sync_q  <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b11;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         rev_q       <= 1'b0;
         len_q       <= LEN_MIN;
         bit_cnt_q   <= {LEN_W{1'b0}};
         tx_shift_q  <= ONES;
         rx_shift_q  <= ONES;
         tx_hold_q   <= {CHAR_NBITS{1'b0}};
         tx_empty_q  <= 1'b1;
         rx_data_q   <= {CHAR_NBITS{1'b0}};
         rx_valid_q  <= 1'b0;
         rx_done_q   <= 1'b0;
         udr_q       <= 1'b0;
         ovr_q       <= 1'b0;
         miso_q      <= 1'b1;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         rev_q       <= rev_d;
         len_q       <= len_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         tx_hold_q   <= tx_hold_d;
         tx_empty_q  <= tx_empty_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_done_q   <= rx_done_d;
         udr_q       <= udr_d;
         ovr_q       <= ovr_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
      end
   end

   assign S_TX_READY    = tx_empty_q;
   assign S_RX_DATA     = rx_data_q;
   assign S_RX_VALID    = rx_valid_q;
   assign S_TX_UDR      = udr_q;
   assign S_RX_OVR      = ovr_q;
   assign S_BUSY        = (state_q == ST_ACTIVE);
   assign S_SPI_MISO    = miso_q;
   assign S_SPI_MISO_OE = oe_q;

endmodule

// File: tb/tb_spi_slave_trx_sync.sv
// Self-checking bench for spi_slave_trx_sync: SPI master driver plus a transaction-level
// model of the holding registers, flags and expected characters.
module tb_spi_slave_trx_sync;

   localparam int H = 5;

   logic        clk = 1'b0;
   logic        S_RESETN, S_ENABLE, S_CPOL, S_CPHA, S_REV, S_LOOP;
   logic [4:0]  S_CHAR_LEN;
   logic [31:0] S_TX_DATA, S_RX_DATA;
   logic        S_TX_VALID, S_TX_READY, S_RX_VALID, S_RX_READY;
   logic        S_TX_UDR, S_RX_OVR, S_ERR_CLR, S_BUSY;
   logic        S_SPI_CS, S_SPI_SCK, S_SPI_MOSI, S_SPI_MISO, S_SPI_MISO_OE;

   int n_cmp = 0;
   int n_err = 0;

   logic        m_hold_full, m_rx_valid, m_udr, m_ovr;
   logic [31:0] m_hold, m_rx_data;

   always #5 clk = ~clk;

   spi_slave_trx_sync dut (
      .S_SYSCLK(clk), .S_RESETN(S_RESETN), .S_ENABLE(S_ENABLE),
      .S_CPOL(S_CPOL), .S_CPHA(S_CPHA), .S_REV(S_REV), .S_CHAR_LEN(S_CHAR_LEN),
      .S_LOOP(S_LOOP), .S_TX_DATA(S_TX_DATA), .S_TX_VALID(S_TX_VALID),
      .S_TX_READY(S_TX_READY), .S_RX_DATA(S_RX_DATA), .S_RX_VALID(S_RX_VALID),
      .S_RX_READY(S_RX_READY), .S_TX_UDR(S_TX_UDR), .S_RX_OVR(S_RX_OVR),
      .S_ERR_CLR(S_ERR_CLR), .S_BUSY(S_BUSY), .S_SPI_CS(S_SPI_CS),
      .S_SPI_SCK(S_SPI_SCK), .S_SPI_MOSI(S_SPI_MOSI), .S_SPI_MISO(S_SPI_MISO),
      .S_SPI_MISO_OE(S_SPI_MISO_OE)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_load(output logic [31:0] v);
      if (m_hold_full) begin
         v = m_hold;
         m_hold_full = 1'b0;
      end else begin
         v = 32'hFFFF_FFFF;
         m_udr = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_hold_full = 1'b0; m_hold = 32'd0; m_rx_valid = 1'b0; m_rx_data = 32'd0;
      m_udr = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " miso"},  32'(S_SPI_MISO), 32'd1);
      check_eq({tag, " oe"},    32'(S_SPI_MISO_OE), 32'd0);
      check_eq({tag, " busy"},  32'(S_BUSY), 32'd0);
      check_eq({tag, " txrdy"}, 32'(S_TX_READY), 32'd1);
      check_eq({tag, " rxvld"}, 32'(S_RX_VALID), 32'd0);
      check_eq({tag, " rxdat"}, S_RX_DATA, 32'd0);
      check_eq({tag, " udr"},   32'(S_TX_UDR), 32'd0);
      check_eq({tag, " ovr"},   32'(S_RX_OVR), 32'd0);
   endtask

   // Half SCK period; optionally issues a one-cycle TX write on its first clock
   task automatic half_wait(input bit wr, input logic [31:0] d);
      for (int k = 0; k < H; k++) begin
         @(negedge clk);
         if (wr && k == 0) begin
            S_TX_DATA  = d;
            S_TX_VALID = 1'b1;
         end else begin
            S_TX_VALID = 1'b0;
         end
      end
   endtask

   task automatic tx_write(input logic [31:0] d);
      int k = 0;
      while (!S_TX_READY && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("txrdy before write", 32'(S_TX_READY), 32'd1);
      S_TX_DATA  = d;
      S_TX_VALID = 1'b1;
      @(negedge clk);
      S_TX_VALID = 1'b0;
      check_eq("txrdy after write", 32'(S_TX_READY), 32'd0);
      m_hold_full = 1'b1;
      m_hold      = d;
   endtask

   task automatic spi_xfer(input bit cpol, input bit cpha, input bit rev, input logic [4:0] cl,
                           input int nchars, input int abort_after,
                           input logic [31:0] mo0, input logic [31:0] mo1,
                           input bit midwr, input logic [31:0] midval,
                           output logic [31:0] mi0, output logic [31:0] mi1,
                           output bit busy_mid, output bit oe_mid);
      int len, idx;
      bit stop;
      logic [31:0] mo[2];
      logic [31:0] mi[2];
      len = (cl < 5'd3) ? 4 : int'(cl) + 1;
      mo[0] = mo0; mo[1] = mo1; mi[0] = 32'd0; mi[1] = 32'd0;
      busy_mid = 1'b0; oe_mid = 1'b0; stop = 1'b0;
      @(negedge clk);
      S_CPOL = cpol; S_CPHA = cpha; S_REV = rev; S_CHAR_LEN = cl; S_SPI_SCK = cpol;
      repeat (2) @(negedge clk);
      S_SPI_CS = 1'b0;
      for (int c = 0; c < nchars && !stop; c++) begin
         for (int i = 0; i < len; i++) begin
            idx = rev ? (len - 1 - i) : i;
            if (abort_after >= 0 && c == 0 && i == abort_after) begin
               stop = 1'b1;
               break;
            end
            if (c == 0 && i == 1) begin
               busy_mid = S_BUSY;
               oe_mid   = S_SPI_MISO_OE;
            end
            if (!cpha) begin
               S_SPI_MOSI = mo[c][idx];
               half_wait(midwr && c == 0 && i == 2, midval);
               mi[c][idx] = S_SPI_MISO;
               S_SPI_SCK  = ~cpol;
               half_wait(1'b0, 32'd0);
               S_SPI_SCK  = cpol;
            end else begin
               half_wait(midwr && c == 0 && i == 2, midval);
               S_SPI_SCK  = ~cpol;
               S_SPI_MOSI = mo[c][idx];
               half_wait(1'b0, 32'd0);
               mi[c][idx] = S_SPI_MISO;
               S_SPI_SCK  = cpol;
            end
         end
      end
      half_wait(1'b0, 32'd0);
      S_SPI_CS = 1'b1;
      repeat (6) @(negedge clk);
      mi0 = mi[0];
      mi1 = mi[1];
   endtask

   // One CS frame: predict loads/RX from the model, run the master, compare
   task automatic run_case(input string name, input bit cpol, input bit cpha, input bit rev,
                           input logic [4:0] cl, input int nchars, input int abort_after,
                           input logic [31:0] mo0, input logic [31:0] mo1,
                           input bit prewr, input logic [31:0] pre,
                           input bit midwr, input logic [31:0] mid, input bit loop);
      int len, completed;
      logic [31:0] mask, rxc, mi0, mi1;
      logic [31:0] ld[3];
      logic [31:0] mo[2];
      bit busy_mid, oe_mid;
      len  = (cl < 5'd3) ? 4 : int'(cl) + 1;
      mask = (len == 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
      mo[0] = mo0; mo[1] = mo1;
      if (prewr) tx_write(pre);
      S_LOOP = loop;
      model_load(ld[0]);
      if (midwr) begin
         m_hold_full = 1'b1;
         m_hold      = mid;
      end
      completed = (abort_after >= 0) ? 0 : nchars;
      for (int c = 0; c < completed; c++) begin
         rxc = loop ? (ld[c] & mask) : (mo[c] & mask);
         if (!m_rx_valid) begin
            m_rx_valid = 1'b1;
            m_rx_data  = rxc;
         end else begin
            m_ovr = 1'b1;
         end
         model_load(ld[c + 1]);
      end
      spi_xfer(cpol, cpha, rev, cl, nchars, abort_after, mo0, mo1, midwr, mid,
               mi0, mi1, busy_mid, oe_mid);
      if (completed >= 1) check_eq({name, " miso0"}, mi0, ld[0] & mask);
      if (completed >= 2) check_eq({name, " miso1"}, mi1, ld[1] & mask);
      if (abort_after < 0 || abort_after >= 2) begin
         check_eq({name, " busy_mid"}, 32'(busy_mid), 32'd1);
         check_eq({name, " oe_mid"}, 32'(oe_mid), loop ? 32'd0 : 32'd1);
      end
      check_eq({name, " rxvld"}, 32'(S_RX_VALID), 32'(m_rx_valid));
      if (m_rx_valid) check_eq({name, " rxdat"}, S_RX_DATA, m_rx_data);
      check_eq({name, " udr"},   32'(S_TX_UDR), 32'(m_udr));
      check_eq({name, " ovr"},   32'(S_RX_OVR), 32'(m_ovr));
      check_eq({name, " txrdy"}, 32'(S_TX_READY), 32'(!m_hold_full));
      check_eq({name, " busy"},  32'(S_BUSY), 32'd0);
      check_eq({name, " miso"},  32'(S_SPI_MISO), 32'd1);
      check_eq({name, " oe"},    32'(S_SPI_MISO_OE), 32'd0);
      S_LOOP = 1'b0;
   endtask

   task automatic cleanup();
      @(negedge clk);
      S_ERR_CLR = 1'b1; S_RX_READY = 1'b1;
      @(negedge clk);
      S_ERR_CLR = 1'b0; S_RX_READY = 1'b0;
      m_udr = 1'b0; m_ovr = 1'b0; m_rx_valid = 1'b0;
      @(negedge clk);
      check_eq("clr udr", 32'(S_TX_UDR), 32'(m_udr));
      check_eq("clr ovr", 32'(S_RX_OVR), 32'(m_ovr));
      check_eq("pop rxvld", 32'(S_RX_VALID), 32'(m_rx_valid));
   endtask

   initial begin
      logic [4:0] cl;
      int len, nch, ab;
      bit mw, pw, cpol, cpha, rev;

      S_RESETN = 1'b0; S_ENABLE = 1'b1; S_CPOL = 1'b0; S_CPHA = 1'b0; S_REV = 1'b1;
      S_CHAR_LEN = 5'd7; S_LOOP = 1'b0; S_TX_DATA = 32'd0; S_TX_VALID = 1'b0;
      S_RX_READY = 1'b0; S_ERR_CLR = 1'b0; S_SPI_CS = 1'b1; S_SPI_SCK = 1'b0; S_SPI_MOSI = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      S_RESETN = 1'b1;
      repeat (3) @(negedge clk);

      run_case("m0_msb8", 1'b0, 1'b0, 1'b1, 5'd7, 1, -1, 32'h3C, 32'h0, 1'b1, 32'hA5, 1'b0, 32'h0, 1'b0);
      cleanup();

      for (int m = 1; m < 4; m++) begin
         run_case("lsb16", 1'(m >> 1), 1'(m & 1), 1'b0, 5'd15, 1, -1, 32'hBEEF, 32'h0,
                  1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
         cleanup();
      end

      run_case("b2b_ovr", 1'b0, 1'b0, 1'b1, 5'd7, 2, -1, 32'h11, 32'h22, 1'b1, 32'hAA, 1'b0, 32'h0, 1'b0);
      cleanup();

      run_case("udr32", 1'b0, 1'b0, 1'b1, 5'd31, 1, -1, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cleanup();

      run_case("abort5", 1'b0, 1'b0, 1'b1, 5'd7, 1, 5, 32'h3C, 32'h0, 1'b1, 32'hC3, 1'b0, 32'h0, 1'b0);
      run_case("after_abort", 1'b0, 1'b0, 1'b1, 5'd7, 1, -1, 32'h5B, 32'h0, 1'b1, 32'h96, 1'b0, 32'h0, 1'b0);
      cleanup();

      run_case("short_len", 1'b1, 1'b1, 1'b1, 5'd1, 2, -1, 32'h0000_0009, 32'h0000_0006,
               1'b1, 32'hFFFF_FFF3, 1'b1, 32'h0000_000C, 1'b0);
      cleanup();

      for (int t = 0; t < 24; t++) begin
         cl   = 5'($urandom_range(0, 31));
         len  = (cl < 5'd3) ? 4 : int'(cl) + 1;
         nch  = int'($urandom_range(1, 2));
         ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, len - 1)) : -1;
         mw   = (ab < 0) && ($urandom_range(0, 1) == 1);
         pw   = 1'($urandom_range(0, 1));
         cpol = 1'($urandom_range(0, 1));
         cpha = 1'($urandom_range(0, 1));
         rev  = 1'($urandom_range(0, 1));
         run_case("rnd", cpol, cpha, rev, cl, nch, ab, $urandom, $urandom, pw, $urandom, mw, $urandom, 1'b0);
         cleanup();
      end

`ifdef SPI_SLAVE_LOOP_EN
      run_case("loop", 1'b0, 1'b0, 1'b1, 5'd7, 1, -1, 32'h00, 32'h0, 1'b1, 32'h5A, 1'b0, 32'h0, 1'b1);
      cleanup();
`endif

      // Reset in the middle of a character
      @(negedge clk);
      S_CPOL = 1'b0; S_CPHA = 1'b0; S_REV = 1'b1; S_CHAR_LEN = 5'd7; S_SPI_SCK = 1'b0;
      repeat (2) @(negedge clk);
      S_SPI_CS = 1'b0;
      repeat (8) @(negedge clk);
      S_SPI_SCK = 1'b1;
      repeat (H) @(negedge clk);
      S_SPI_SCK = 1'b0;
      repeat (H) @(negedge clk);
      check_eq("midchar busy", 32'(S_BUSY), 32'd1);
      S_RESETN = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_outputs("rst_mid");
      S_SPI_CS = 1'b1;
      repeat (3) @(negedge clk);
      S_RESETN = 1'b1;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
